grid_parity_corrector: RTL and testbench

//  Parametrised 2-D (row/column) parity protector for a ROWS x COLS data grid.
//  It captures a word and its row/column parity, and can inject a single bit

---
 rtl/grid_parity_corrector_if.sv | 33 +++
 rtl/grid_parity_corrector.sv | 160 ++++++++++++++++
 tb/tb_grid_parity_corrector.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_parity_corrector_if.sv
// Handshake/data bundle between the key-input layer and the 2-D parity corrector.
// master drives commands and data; slave is the corrector itself.
interface grid_parity_corrector_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);

  logic            load;
  logic [N-1:0]    din;
  logic            inject;
  logic            check;
  logic            correct_en;
  logic [N-1:0]    data_out;
  logic [ROWS-1:0] row_par;
  logic [COLS-1:0] col_par;
  logic [IW-1:0]   inj_idx;
  logic            busy;
  logic            done;
  logic [1:0]      status;
  logic [IW-1:0]   err_idx;

  modport master (
    output load, din, inject, check, correct_en,
    input  data_out, row_par, col_par, inj_idx, busy, done, status, err_idx
  );

  modport slave (
    input  load, din, inject, check, correct_en,
    output data_out, row_par, col_par, inj_idx, busy, done, status, err_idx
  );
endinterface

// File: rtl/grid_parity_corrector.sv
// ROWS x COLS row/column parity protector: captures a word with its parity, injects
// single-bit faults at an LFSR-chosen index, then scans, classifies and optionally repairs.
module grid_parity_corrector #(
  parameter int          ROWS = 4,
  parameter int          COLS = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  grid_parity_corrector_if.slave  bus
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int MX = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW = $clog2(MX);
  localparam int PW = CW + 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SROW = 3'd1;
  localparam logic [2:0] S_SCOL = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_data;
  logic [ROWS-1:0] r_row_par;
  logic [COLS-1:0] r_col_par;
  logic [ROWS-1:0] r_rflag;
  logic [COLS-1:0] r_cflag;
  logic [1:0]      r_status;
  logic [IW-1:0]   r_err_idx;
  logic [15:0]     r_lfsr;
  logic            r_corr;

  logic [ROWS-1:0] w_rowx, w_din_rp;
  logic [COLS-1:0] w_colx, w_din_cp;
  logic [PW-1:0]   w_nr, w_nc;
  logic [IW-1:0]   w_eidx;
  logic [1:0]      w_st;
  logic [IW-1:0]   w_inj;
  logic            w_fb;

  // Parity of the live data (for the scan) and of din (for capture on load).
  always_comb begin
    w_rowx   = '0;
    w_colx   = '0;
    w_din_rp = '0;
    w_din_cp = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_rowx[r]   = w_rowx[r]   ^ r_data[r*COLS+c];
        w_colx[c]   = w_colx[c]   ^ r_data[r*COLS+c];
        w_din_rp[r] = w_din_rp[r] ^ bus.din[r*COLS+c];
        w_din_cp[c] = w_din_cp[c] ^ bus.din[r*COLS+c];
      end
    end
  end

  // Classification of the collected flags; a single row/col intersection locates the bit.
  always_comb begin
    w_nr   = '0;
    w_nc   = '0;
    w_eidx = '0;
    for (int r = 0; r < ROWS; r++) w_nr = w_nr + PW'(r_rflag[r]);
    for (int c = 0; c < COLS; c++) w_nc = w_nc + PW'(r_cflag[c]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r_rflag[r] && r_cflag[c]) w_eidx = IW'(r*COLS + c);
    if (w_nr == '0 && w_nc == '0)
      w_st = 2'b00;
    else if (w_nr == PW'(1) && w_nc == PW'(1))
      w_st = 2'b01;
    else if ((w_nr == PW'(1) && w_nc == '0) || (w_nr == '0 && w_nc == PW'(1)))
      w_st = 2'b10;
    else
      w_st = 2'b11;
  end

  assign w_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_inj = IW'(r_lfsr % N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_row_par <= '0;
      r_col_par <= '0;
      r_rflag   <= '0;
      r_cflag   <= '0;
      r_status  <= 2'b00;
      r_err_idx <= '0;
      r_lfsr    <= SEED_EFF;
      r_corr    <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_data    <= bus.din;
            r_row_par <= w_din_rp;
            r_col_par <= w_din_cp;
            r_status  <= 2'b00;
            r_err_idx <= '0;
          end else if (bus.inject) begin
            r_data <= r_data ^ (N'(1) << w_inj);
          end else if (bus.check) begin
            r_corr  <= bus.correct_en;
            r_cnt   <= '0;
            r_state <= S_SROW;
          end
        end
        S_SROW: begin
          for (int r = 0; r < ROWS; r++)
            if (r_cnt == CW'(r)) r_rflag[r] <= w_rowx[r] ^ r_row_par[r];
          if (r_cnt == CW'(ROWS-1)) begin
            r_cnt   <= '0;
            r_state <= S_SCOL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SCOL: begin
          for (int c = 0; c < COLS; c++)
            if (r_cnt == CW'(c)) r_cflag[c] <= w_colx[c] ^ r_col_par[c];
          if (r_cnt == CW'(COLS-1)) begin
            r_cnt   <= '0;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          r_status  <= w_st;
          r_err_idx <= (w_st == 2'b01) ? w_eidx : '0;
          r_state   <= (w_st == 2'b01 && r_corr) ? S_FIX : S_DONE;
        end
        S_FIX: begin
          r_data  <= r_data ^ (N'(1) << r_err_idx);
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out = r_data;
  assign bus.row_par  = r_row_par;
  assign bus.col_par  = r_col_par;
  assign bus.inj_idx  = w_inj;
  assign bus.busy     = (r_state == S_SROW) || (r_state == S_SCOL) ||
                        (r_state == S_EVAL) || (r_state == S_FIX);
  assign bus.done     = (r_state == S_DONE);
  assign bus.status   = r_status;
  assign bus.err_idx  = r_err_idx;
endmodule

// File: tb/tb_grid_parity_corrector.sv
// Randomized and directed bench for grid_parity_corrector against a behavioural grid model.
module tb_grid_parity_corrector;
  localparam int          ROWS = 4;
  localparam int          COLS = 4;
  localparam int          N    = ROWS * COLS;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst;

  grid_parity_corrector_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  grid_parity_corrector #(.ROWS(ROWS), .COLS(COLS), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]     m_lfsr;
  logic [N-1:0]    m_data;
  logic [ROWS-1:0] m_rp;
  logic [COLS-1:0] m_cp;
  logic [1:0]      m_st;
  int              m_err;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int   taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb   = 1'b0;
    foreach (taps[i]) fb = fb ^ s[taps[i]-1];
    return {s[14:0], fb};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic grid_par(input logic [N-1:0] d, output logic [ROWS-1:0] rp,
                          output logic [COLS-1:0] cp);
    rp = '0;
    cp = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rp[r] = rp[r] ^ d[r*COLS+c];
        cp[c] = cp[c] ^ d[r*COLS+c];
      end
  endtask

  // Count mismatching rows/columns against stored parity and classify.
  task automatic model_eval(output logic [1:0] st, output int ei);
    logic [ROWS-1:0] rp;
    logic [COLS-1:0] cp;
    int nr, nc, rr, cc;
    grid_par(m_data, rp, cp);
    nr = 0; nc = 0; rr = 0; cc = 0;
    for (int r = 0; r < ROWS; r++) if (rp[r] != m_rp[r]) begin nr++; rr = r; end
    for (int c = 0; c < COLS; c++) if (cp[c] != m_cp[c]) begin nc++; cc = c; end
    ei = 0;
    if (nr == 0 && nc == 0)      st = 2'b00;
    else if (nr == 1 && nc == 1) begin st = 2'b01; ei = rr*COLS + cc; end
    else if (nr + nc == 1)       st = 2'b10;
    else                         st = 2'b11;
  endtask

  task automatic do_load(input logic [N-1:0] d);
    bus.load = 1'b1;
    bus.din  = d;
    @(negedge clk);
    bus.load = 1'b0;
    m_data = d;
    grid_par(d, m_rp, m_cp);
    m_st  = 2'b00;
    m_err = 0;
    chk("load_data", 32'(bus.data_out), 32'(m_data));
    chk("row_par",   32'(bus.row_par),  32'(m_rp));
    chk("col_par",   32'(bus.col_par),  32'(m_cp));
  endtask

  task automatic do_inject(output int k);
    k = int'(m_lfsr % N);
    chk("inj_idx", 32'(bus.inj_idx), 32'(k));
    bus.inject = 1'b1;
    @(negedge clk);
    bus.inject = 1'b0;
    m_data[k] = ~m_data[k];
    chk("inject_data", 32'(bus.data_out), 32'(m_data));
  endtask

  task automatic do_check(input bit ce);
    int n, lat;
    bus.check      = 1'b1;
    bus.correct_en = ce;
    @(negedge clk);
    bus.check      = 1'b0;
    bus.correct_en = 1'b0;
    n = 1;
    chk("busy_start", 32'(bus.busy), 32'd1);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    model_eval(m_st, m_err);
    lat = (m_st == 2'b01 && ce) ? ROWS+COLS+3 : ROWS+COLS+2;
    if (m_st == 2'b01 && ce) m_data[m_err] = ~m_data[m_err];
    chk("latency",   32'(n),            32'(lat));
    chk("busy_done", 32'(bus.busy),     32'd0);
    chk("status",    32'(bus.status),   32'(m_st));
    chk("err_idx",   32'(bus.err_idx),  32'(m_err));
    chk("data_done", 32'(bus.data_out), 32'(m_data));
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_idx(input int v);
    int t;
    t = 0;
    while (int'(m_lfsr % N) != v && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idx", 32'(bus.inj_idx), 32'(v));
  endtask

  initial begin
    int k;
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.din        = '0;
    bus.inject     = 1'b0;
    bus.check      = 1'b0;
    bus.correct_en = 1'b0;
    m_data = '0; m_rp = '0; m_cp = '0; m_st = 2'b00; m_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_data",   32'(bus.data_out), 32'd0);
    chk("rst_rowpar", 32'(bus.row_par),  32'd0);
    chk("rst_colpar", 32'(bus.col_par),  32'd0);
    chk("rst_status", 32'(bus.status),   32'd0);
    chk("rst_busy",   32'(bus.busy),     32'd0);
    chk("rst_done",   32'(bus.done),     32'd0);
    chk("rst_inj",    32'(bus.inj_idx),  32'(SEED % N));
    rst = 1'b0;
    @(negedge clk);

    // clean scan
    do_load(16'h1234);
    do_check(1'b0);
    // single fault, repaired and unrepaired
    do_load(16'h1234);
    do_inject(k);
    do_check(1'b1);
    chk("t2_data", 32'(bus.data_out), 32'h1234);
    do_load(16'h1234);
    do_inject(k);
    do_check(1'b0);
    chk("t3_data", 32'(bus.data_out), 32'(16'h1234 ^ (16'h1 << k)));
    // two faults at bits 0 and 5: uncorrectable
    do_load(16'h1234);
    wait_idx(0);
    do_inject(k);
    wait_idx(5);
    do_inject(k);
    do_check(1'b1);
    chk("t4_status", 32'(bus.status), 32'd3);
    chk("t4_data",   32'(bus.data_out), 32'(16'h1234 ^ 16'h0021));

    // load beats inject; load during a scan is ignored
    bus.load = 1'b1; bus.inject = 1'b1; bus.din = 16'hA5A5;
    @(negedge clk);
    bus.load = 1'b0; bus.inject = 1'b0;
    m_data = 16'hA5A5; grid_par(m_data, m_rp, m_cp); m_st = 2'b00; m_err = 0;
    chk("t5_prio", 32'(bus.data_out), 32'hA5A5);
    bus.check = 1'b1;
    @(negedge clk);
    bus.check = 1'b0;
    @(negedge clk);
    bus.load = 1'b1; bus.din = 16'hFFFF;
    @(negedge clk);
    bus.load = 1'b0;
    begin
      int t;
      t = 0;
      while (!bus.done && t < 40) begin @(negedge clk); t++; end
      chk("t5_done_seen", 32'(bus.done), 32'd1);
    end
    chk("t5_busy_load", 32'(bus.data_out), 32'hA5A5);
    chk("t5_status",    32'(bus.status),   32'd0);
    @(negedge clk);

    // reset mid SCAN_COL, with a non-zero status held beforehand
    do_load(16'hBEEF);
    do_inject(k);
    do_check(1'b0);
    chk("t6_pre_status", 32'(bus.status), 32'd1);
    bus.check = 1'b1;
    @(negedge clk);
    bus.check = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy",   32'(bus.busy),     32'd0);
    chk("t6_status", 32'(bus.status),   32'd0);
    chk("t6_data",   32'(bus.data_out), 32'd0);
    chk("t6_done",   32'(bus.done),     32'd0);
    chk("t6_inj",    32'(bus.inj_idx),  32'(SEED % N));
    @(negedge clk);
    rst = 1'b0;
    m_data = '0; m_rp = '0; m_cp = '0; m_st = 2'b00; m_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(bus.done),    32'd0);
      chk("t6_inj_seq", 32'(bus.inj_idx), 32'(m_lfsr % N));
    end

    // randomized load / inject / check sequences
    for (int it = 0; it < 30; it++) begin
      int ni;
      do_load(N'($urandom));
      ni = $urandom_range(0, 2);
      for (int j = 0; j < ni; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_inject(k);
      end
      do_check(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
